// File: rtl/mem_arb.sv
// Arbitrates n_m requesters onto one byte-enable single-port memory; one access per 3 cycles.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module mem_arb #(
    parameter int n_m   = 2,
    parameter int depth = 8,
    parameter int a_w   = $clog2(depth),
    parameter int d_w   = 32,
    parameter int b_c   = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [n_m-1:0]     req,
    input  logic [n_m*a_w-1:0] addr,
    input  logic [n_m*b_c-1:0] we,
    input  logic [n_m*d_w-1:0] wd,
    output logic [n_m-1:0]     ack,
    output logic [d_w-1:0]     rd,
    output logic               busy,
    output logic [a_w-1:0]     m_addr,
    output logic [b_c-1:0]     m_we,
    output logic [d_w-1:0]     m_wd,
    input  logic [d_w-1:0]     m_rd
);

    localparam int g_w = (n_m > 1) ? $clog2(n_m) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t         state_q, state_d;
    logic [g_w-1:0] g_q, g_d;
    logic [g_w-1:0] win;
    logic           win_vld;
    logic [a_w-1:0] m_addr_q, m_addr_d;
    logic [b_c-1:0] m_we_q, m_we_d;
    logic [d_w-1:0] m_wd_q, m_wd_d;
    logic [d_w-1:0] rd_q, rd_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [g_w-1:0] rr_q, rr_d;
`endif

    // Winner selection over the live request vector
    always_comb begin
        logic [g_w-1:0] cand;
        int             idx;
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        idx     = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = n_m - 1; i >= 0; i--) begin
            cand = g_w'(i);
            if (req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
`else
        for (int k = 0; k < n_m; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= n_m) idx = idx - n_m;
            cand = g_w'(idx);
            if (!win_vld && req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            g_q      <= '0;
            m_addr_q <= '0;
            m_we_q   <= '0;
            m_wd_q   <= '0;
            rd_q     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            m_addr_q <= m_addr_d;
            m_we_q   <= m_we_d;
            m_wd_q   <= m_wd_d;
            rd_q     <= rd_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_q     <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // m_we defaults to zero so the write strobe lives only for the ACCESS cycle
    always_comb begin
        g_d      = g_q;
        m_addr_d = m_addr_q;
        m_we_d   = '0;
        m_wd_d   = m_wd_q;
        rd_d     = rd_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    g_d      = win;
                    m_addr_d = addr[win*a_w +: a_w];
                    m_we_d   = we[win*b_c +: b_c];
                    m_wd_d   = wd[win*d_w +: d_w];
                end
            end
            ACCESS: rd_d = m_rd;
            RESP: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                rr_d = (g_q == g_w'(n_m - 1)) ? '0 : g_q + g_w'(1);
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state_q == RESP) ack[g_q] = 1'b1;
        busy = (state_q != IDLE);
    end

    assign rd     = rd_q;
    assign m_addr = m_addr_q;
    assign m_we   = m_we_q;
    assign m_wd   = m_wd_q;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: 4 masters over an 8x32 byte-enable memory model.
module tb_mem_arb;

    localparam int NM = 4;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int BC = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NM-1:0]     req;
    logic [NM*AW-1:0]  addr;
    logic [NM*BC-1:0]  we;
    logic [NM*DW-1:0]  wd;
    logic [NM-1:0]     ack;
    logic [DW-1:0]     rd;
    logic              busy;
    logic [AW-1:0]     m_addr;
    logic [BC-1:0]     m_we;
    logic [DW-1:0]     m_wd;
    logic [DW-1:0]     m_rd;

    typedef struct {
        int          m;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    logic [31:0] mem [8] = '{default: 32'h0};

    mem_arb #(.n_m(NM), .depth(8), .a_w(AW), .d_w(DW), .b_c(BC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .addr   (addr),
        .we     (we),
        .wd     (wd),
        .ack    (ack),
        .rd     (rd),
        .busy   (busy),
        .m_addr (m_addr),
        .m_we   (m_we),
        .m_wd   (m_wd),
        .m_rd   (m_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, byte-enabled write on the clock edge
    assign m_rd = mem[m_addr];
    always @(posedge clk) begin
        for (int b = 0; b < BC; b++)
            if (m_we[b]) mem[m_addr][b*8 +: 8] <= m_wd[b*8 +: 8];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Completion monitor: every ack pops one expectation
    always @(negedge clk) begin
        exp_t        e;
        logic [NM-1:0] oh;
        if (resetn && ack != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'(ack), 64'h0);
            end else begin
                e = sb.pop_front();
                oh = '0;
                oh[e.m] = 1'b1;
                chk("ack", 64'(ack), 64'(oh));
                chk("rd", 64'(rd), 64'(e.rd));
                chk("busy_resp", 64'(busy), 64'h1);
                chk("m_we_resp", 64'(m_we), 64'h0);
            end
        end
    end

    task automatic set_master(input int m, input logic [2:0] a, input logic [3:0] be,
                              input logic [31:0] d);
        addr[m*AW +: AW] = a;
        we[m*BC +: BC]   = be;
        wd[m*DW +: DW]   = d;
    endtask

    task automatic do_access(input int m, input logic [2:0] a, input logic [3:0] be,
                             input logic [31:0] d, input logic [31:0] exp_rd);
        int c0;
        bit seen;
        @(negedge clk);
        set_master(m, a, be, d);
        req[m] = 1'b1;
        sb.push_back('{m, exp_rd});
        c0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ack[m]) seen = 1'b1;
        end
        chk("latency", seen ? 64'(cyc - c0) : 64'hFFFF, 64'd2);
        req[m] = 1'b0;
    endtask

    task automatic wait_ack(input string tag, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ack != '0) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'h1);
    endtask

    initial begin
        bit seen;
        int last;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int last;
        resetn = 1'b0;
        req = '0; addr = '0; we = '0; wd = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_rd", 64'(rd), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_m_addr", 64'(m_addr), 64'h0);
        chk("rst_m_we", 64'(m_we), 64'h0);
        chk("rst_m_wd", 64'(m_wd), 64'h0);
        resetn = 1'b1;

        // Reset during the ACCESS cycle of a write aborts it
        @(negedge clk);
        set_master(0, 3'd6, 4'hF, 32'hCAFEF00D);
        req[0] = 1'b1;
        @(negedge clk);
        chk("abort_busy_pre", 64'(busy), 64'h1);
        chk("abort_we_pre", 64'(m_we), 64'hF);
        resetn = 1'b0;
        #1;
        chk("abort_m_we", 64'(m_we), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_ack", 64'(ack), 64'h0);
        req = '0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_mem", 64'(mem[6]), 64'h0);
        do_access(0, 3'd6, 4'h0, 32'h0, 32'h0);

        // Full write then read; a write returns the old word
        do_access(0, 3'd3, 4'hF, 32'hDEADBEEF, 32'h0);
        do_access(0, 3'd3, 4'h0, 32'h0, 32'hDEADBEEF);

        // Byte-enable merge
        do_access(0, 3'd5, 4'hF, 32'h11223344, 32'h0);
        do_access(0, 3'd5, 4'b0010, 32'h0000AA00, 32'h11223344);
        do_access(0, 3'd5, 4'h0, 32'h0, 32'h1122AA44);
        chk("mem_merge", 64'(mem[5]), 64'h1122AA44);

        // Master 3 access moves the round-robin pointer back to 0
        do_access(3, 3'd3, 4'h0, 32'h0, 32'hDEADBEEF);

        // Contention: masters 0 and 1 hold req for four grants
        @(negedge clk);
        set_master(0, 3'd3, 4'h0, 32'h0);
        set_master(1, 3'd5, 4'h0, 32'h0);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            sb.push_back('{0, 32'hDEADBEEF});
`else
            if (k % 2 == 0) sb.push_back('{0, 32'hDEADBEEF});
            else            sb.push_back('{1, 32'h1122AA44});
`endif
        end
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack("cont_ack_seen", seen);
            if (k > 0) chk("b2b_gap", 64'(cyc - last), 64'd3);
            last = cyc;
            if (k == 3) req = '0;
            @(negedge clk);
            chk("b2b_busy_gap", 64'(busy), 64'h0);
        end

        // Master 2 access leaves the pointer at 3 for the wrap case
        do_access(2, 3'd5, 4'h0, 32'h0, 32'h1122AA44);

        @(negedge clk);
        set_master(3, 3'd5, 4'h0, 32'h0);
        set_master(0, 3'd3, 4'h0, 32'h0);
        req = 4'b1001;
`ifdef MEM_ARB_FIXED_PRIO_EN
        sb.push_back('{0, 32'hDEADBEEF});
        sb.push_back('{3, 32'h1122AA44});
`else
        sb.push_back('{3, 32'h1122AA44});
        sb.push_back('{0, 32'hDEADBEEF});
`endif
        for (int k = 0; k < 2; k++) begin
            wait_ack("wrap_ack_seen", seen);
            req = req & ~ack;
        end
        req = '0;

        repeat (6) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        chk("idle_busy", 64'(busy), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
